// File: rtl/fetch_pkg.sv
// Shared constants for the SRAM-like instruction fetch stage: reset vector,
// transfer size encoding and the {adef, inst, pc} bus layout.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h1C00_0000;
  localparam int          PC_W_DEF     = 32;
  localparam int          INST_W_DEF   = 32;
  localparam logic [1:0]  SIZE_WORD    = 2'b10;

  localparam int FS_TO_DS_BUS_W = PC_W_DEF + INST_W_DEF + 1;
  localparam int BUS_PC_LSB     = 0;
  localparam int BUS_INST_LSB   = PC_W_DEF;
  localparam int BUS_ADEF_BIT   = PC_W_DEF + INST_W_DEF;

  // A single-entry FIFO still needs a one-bit pointer.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fetch_stage_sramlike_fifo.sv
// Synchronous FIFO with clear; a push into a full FIFO is accepted when a pop
// happens in the same cycle. Storage is not reset, only pointers and count.
module sync_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_stage_sramlike.sv
// Instruction fetch over a split-transaction SRAM-like bus with several requests
// in flight. Optional macro FETCH_ADEF_EN reports misaligned fetch PCs as adef.
module fetch_stage_sramlike
  import fetch_pkg::*;
#(
  parameter int              PC_W      = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC  = PC_W'(RESET_PC_DEF),
  parameter int              INST_W    = INST_W_DEF,
  parameter int              MAX_OUTST = 2,
  parameter int              IQ_DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ds_allowin,
  input  logic                     br_taken,
  input  logic [PC_W-1:0]          br_target,
  input  logic                     flush,
  input  logic [PC_W-1:0]          flush_pc,
  output logic                     fs_to_ds_valid,
  output logic [PC_W+INST_W:0]     fs_to_ds_bus,
  output logic                     inst_sram_req,
  output logic                     inst_sram_wr,
  output logic [1:0]               inst_sram_size,
  output logic [PC_W-1:0]          inst_sram_addr,
  output logic [INST_W-1:0]        inst_sram_wdata,
  input  logic                     inst_sram_addr_ok,
  input  logic                     inst_sram_data_ok,
  input  logic [INST_W-1:0]        inst_sram_rdata
);

  localparam int BUS_W  = PC_W + INST_W + 1;
  localparam int OCNT_W = $clog2(MAX_OUTST + 1);
  localparam int QCNT_W = $clog2(IQ_DEPTH + 1);

  logic [PC_W-1:0]   pf_pc;
  logic [OCNT_W-1:0] outst;
  logic [OCNT_W-1:0] discard_cnt;
  logic [QCNT_W-1:0] iq_cnt;
  logic [PC_W-1:0]   pend_pc;
  logic              pend_full;
  logic              pend_empty;
  logic              iq_full;
  logic              iq_empty;
  logic [BUS_W-1:0]  iq_push_data;
  logic              redirect;
  logic              room;
  logic              fetch_ok;
  logic              adef_push;
  logic              hs;
  logic              resp;
  logic              resp_keep;
  logic              iq_push;
  logic              iq_pop;

  assign redirect = flush || br_taken;
  // Counting queued plus in-flight entries reserves a slot for every live response.
  assign room     = (32'(outst) + 32'(iq_cnt)) < 32'(IQ_DEPTH);

`ifdef FETCH_ADEF_EN
  logic adef_done;
  logic pc_misaligned;

  assign pc_misaligned = (pf_pc[1:0] != 2'b00);
  assign fetch_ok      = !pc_misaligned;
  assign adef_push     = pc_misaligned && !adef_done && !redirect &&
                         (outst == '0) && (discard_cnt == '0) && !iq_full;

  always_ff @(posedge clk) begin
    if (reset || redirect) adef_done <= 1'b0;
    else if (adef_push)    adef_done <= 1'b1;
  end
`else
  assign fetch_ok  = 1'b1;
  assign adef_push = 1'b0;
`endif

  assign inst_sram_req   = !reset && !redirect && !pend_full && room && !iq_full && fetch_ok;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = SIZE_WORD;
  assign inst_sram_addr  = pf_pc;
  assign inst_sram_wdata = '0;

  assign hs        = inst_sram_req && inst_sram_addr_ok;
  assign resp      = inst_sram_data_ok && !pend_empty;
  assign resp_keep = resp && (discard_cnt == '0) && !redirect;
  assign iq_push   = resp_keep || adef_push;
  assign iq_pop    = !iq_empty && ds_allowin && !redirect;
  assign iq_push_data = adef_push ? {1'b1, {INST_W{1'b0}}, pf_pc}
                                  : {1'b0, inst_sram_rdata, pend_pc};

  assign fs_to_ds_valid = !iq_empty;

  sync_fifo #(.WIDTH(PC_W), .DEPTH(MAX_OUTST)) u_pend_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (1'b0),
    .push      (hs),
    .push_data (pf_pc),
    .pop       (resp),
    .pop_data  (pend_pc),
    .full      (pend_full),
    .empty     (pend_empty),
    .count     (outst)
  );

  sync_fifo #(.WIDTH(BUS_W), .DEPTH(IQ_DEPTH)) u_inst_queue (
    .clk       (clk),
    .reset     (reset),
    .clear     (redirect),
    .push      (iq_push),
    .push_data (iq_push_data),
    .pop       (iq_pop),
    .pop_data  (fs_to_ds_bus),
    .full      (iq_full),
    .empty     (iq_empty),
    .count     (iq_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset)         pf_pc <= RESET_PC;
    else if (flush)    pf_pc <= flush_pc;
    else if (br_taken) pf_pc <= br_target;
    else if (hs)       pf_pc <= pf_pc + PC_W'(4);
  end

  // Everything still in flight at a redirect belongs to the old stream.
  always_ff @(posedge clk) begin
    if (reset)                              discard_cnt <= '0;
    else if (redirect)                      discard_cnt <= outst - OCNT_W'(resp);
    else if (resp && (discard_cnt != '0))   discard_cnt <= discard_cnt - 1'b1;
  end

  data_ok_has_request: assert property (@(posedge clk) disable iff (reset)
    inst_sram_data_ok |-> !pend_empty);

endmodule

// File: doc/fetch_stage_sramlike.md
Name: fetch_stage_sramlike

Overview:
- Parametrised instruction-fetch stage for the 5-stage pipeline, replacing the fixed single-cycle-SRAM fetch.
- Talks to instruction memory over the split-transaction SRAM-like protocol (req/addr_ok, data_ok), with several requests in flight at once.
- Buffers fetched {pc, inst} pairs in an instruction queue ahead of decode.
- Handles branch and exception/ertn redirects by discarding stale in-flight responses.

Parameters:
- RESET_PC, 32'h1C000000, first fetch address after reset
- PC_W, 32, PC/address width
- INST_W, 32, instruction width
- MAX_OUTST, 2, max requests accepted (addr_ok) but not yet answered (data_ok); range 1..4
- IQ_DEPTH, 4, instruction queue entries; must be >= MAX_OUTST

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- ds_allowin  in  1  decode accepts an instruction this cycle
- br_taken  in  1  branch redirect from decode
- br_target  in  PC_W  branch target
- flush  in  1  exception/ertn redirect from writeback
- flush_pc  in  PC_W  exception entry or era
- fs_to_ds_valid  out  1  queue head valid
- fs_to_ds_bus  out  PC_W+INST_W+1  {adef, inst, pc}
- inst_sram_req  out  1  request valid
- inst_sram_wr  out  1  constant 0
- inst_sram_size  out  2  constant 2'b10 (word)
- inst_sram_addr  out  PC_W  fetch address
- inst_sram_wdata  out  INST_W  constant 0
- inst_sram_addr_ok  in  1  request accepted
- inst_sram_data_ok  in  1  response valid
- inst_sram_rdata  in  INST_W  response data

Behaviour:
- Reset is synchronous, active-high, on clk; it clears every counter and queue. After reset: pf_pc=RESET_PC, inst_sram_req=0, fs_to_ds_valid=0, discard_cnt=0, outst=0. Reset mid-transaction drops all in-flight state.
- Counters: outst = accepted-not-answered; iq_cnt = queue occupancy.
- Issue: inst_sram_req = !reset && !redirect && outst<MAX_OUTST && (outst+iq_cnt)<IQ_DEPTH. This guarantees queue space for every non-discarded response. inst_sram_addr=pf_pc.
- Handshake (req&&addr_ok): push pf_pc into the pending-PC FIFO (depth MAX_OUTST); pf_pc <= pf_pc+4 (wraps mod 2^PC_W); outst++.
- Response (data_ok): pop the pending-PC FIFO; outst--.
  - discard_cnt>0: drop the data, discard_cnt--.
  - Otherwise push {0, rdata, popped pc} into the instruction queue.
- Same-cycle handshake and data_ok: outst unchanged, both FIFOs updated.
- data_ok with outst==0: protocol error, ignored; simulation assertion fires.
- Output: fs_to_ds_valid = iq_cnt!=0; bus = queue head; pop when valid && ds_allowin. Push and pop in the same cycle are allowed, including when the queue is full.
- Redirect = flush || br_taken. Priority: reset > flush > br_taken.
  - pf_pc <= flush ? flush_pc : br_target.
  - Instruction queue cleared; its same-cycle pop is ignored.
  - No request is issued in the redirect cycle.
  - discard_cnt <= outst - data_ok; a response arriving that cycle is dropped.
  - Back-to-back redirects recompute discard_cnt from outst each time, so stale responses are never double-counted.
- Latency: redirect at cycle N -> first request at N+1; fs_to_ds_valid no earlier than the cycle after the first non-discarded data_ok.

Optional Feature:
- FETCH_ADEF_EN defined:
  - If pf_pc[1:0]!=0: no request is issued.
  - When outst==0 && discard_cnt==0 && queue has space, push {1, INST_W'0, pf_pc} once, then stall fetch until the next redirect.
- FETCH_ADEF_EN undefined: adef bit is constant 0; pf_pc low bits are not checked and the address is issued as is.

Decomposition:
- Shared package fetch_pkg holds:
  - RESET_PC default
  - SIZE_WORD = 2'b10
  - FS_TO_DS_BUS_W = PC_W+INST_W+1
  - bus field offsets
- One sub-module: sync_fifo (params WIDTH, DEPTH; push/pop/clear, full/empty/count), instantiated twice: pending-PC FIFO and instruction queue.

Test Plan:
- Reset, addr_ok=1, data_ok 1 cycle after each accept, ds_allowin=1 -> requests at 1C000000, 1C000004, 1C000008; bus pcs in order, adef=0.
- ds_allowin=0 with IQ_DEPTH=4, MAX_OUTST=2 -> req drops once outst+iq_cnt=4; queue holds 4 entries in order; releasing ds_allowin drains them and fetch resumes at 1C000010.
- br_taken to 1C000100 with 2 outstanding -> the next 2 data_ok are dropped, first delivered pc = 1C000100, no stale pc reaches decode.
- flush (flush_pc 1C008000) and br_taken in the same cycle as a data_ok, outst=2 -> discard_cnt=1, fetch restarts at 1C008000.
- addr_ok held 0 for 5 cycles -> req and addr stay stable at the same pc; no pc increment.
- FETCH_ADEF_EN, br_target 1C000102 -> no request issued, one entry {adef=1, pc=1C000102}, then idle until the next redirect.
